key_event_decoder: RTL

Consumes the debounced key stream (one-cycle `flag` settle strobe plus settled `key_value` level, active-low key) and classifies user gestures into single-click, double-click and long-press events. Each event is a registered one-cycle pulse. An optional auto-repeat pulse train runs while a long press is held. The block sits directly downstream of the key debouncer and feeds the VGA control logic (mode/colour selection).

---
 rtl/key_pkg.sv | 18 +
 rtl/key_edge_track.sv | 36 +++
 rtl/key_event_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing for the key gesture decoder.
// The default timings are 1 s long press, 300 ms double-click gap and 200 ms auto-repeat.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } key_state_e;

  localparam int unsigned LONG_CYC_DEF   = 50_000_000;
  localparam int unsigned DCLK_CYC_DEF   = 15_000_000;
  localparam int unsigned REPEAT_CYC_DEF = 10_000_000;
  localparam int unsigned CNT_W_DEF      = 26;

endpackage

// File: rtl/key_edge_track.sv
// Turns debouncer flag/key_value into press/release strobes; the strobes are combinational in the flag cycle.
// Flag strobes are never stalled; a flag whose level matches the tracked level produces no strobe.
module key_edge_track (
  input  logic clk,
  input  logic rst_n,
  input  logic flag,
  input  logic key_value,
  output logic press_stb,
  output logic release_stb,
  output logic stable_lvl
);

  logic stable_lvl_q;
  logic stable_lvl_d;

  always_comb begin
    stable_lvl_d = stable_lvl_q;
    if (flag) begin
      stable_lvl_d = key_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_lvl_q <= 1'b1;
    end else begin
      stable_lvl_q <= stable_lvl_d;
    end
  end

  // Active-low key: a 1->0 transition is a press.
  assign press_stb   = flag & ~key_value & stable_lvl_q;
  assign release_stb = flag & key_value & ~stable_lvl_q;
  assign stable_lvl  = stable_lvl_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies key gestures into single/double/long pulses (registered, one cycle after detection); no backpressure.
// `KEY_REPEAT_EN adds an auto-repeat pulse train while a long press is held; otherwise repeat_pulse is tied 0.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned DCLK_CYC   = DCLK_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flag,
  input  logic key_value,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_pressed,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_TERM = CNT_W'(DCLK_CYC - 1);

  logic press_stb;
  logic release_stb;
  logic stable_lvl;

  key_edge_track u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag        (flag),
    .key_value   (key_value),
    .press_stb   (press_stb),
    .release_stb (release_stb),
    .stable_lvl  (stable_lvl)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_run;
  logic             cnt_clr;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYC - 1);
  logic repeat_q, repeat_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYC;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_run  = 1'b0;
    cnt_clr  = 1'b0;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d = 1'b0;
`endif
    // Edge strobes are tested before counter terminals so an edge always wins.
    case (state_q)
      IDLE: begin
        if (press_stb) state_d = PRESS1;
      end
      PRESS1: begin
        cnt_run = 1'b1;
        if (release_stb) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_TERM) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      WAIT2: begin
        cnt_run = 1'b1;
        if (press_stb) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLK_TERM) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end
      end
      PRESS2: begin
        if (release_stb) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      LONG: begin
        if (release_stb) begin
          state_d = IDLE;
        end else begin
`ifdef KEY_REPEAT_EN
          cnt_run = 1'b1;
          if (cnt_q == REP_TERM) begin
            repeat_d = 1'b1;
            cnt_clr  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_clr = 1'b1;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_run && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign single_pulse = single_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign key_pressed  = ~stable_lvl;
  assign busy         = (state_q != IDLE);

endmodule
